uart_tx_fifo: RTL

- Buffered 8N1/8N2 UART transmitter: bytes are pushed through a valid/busy handshake into a small FIFO and serialised LSB-first on out_signal at a fixed bit period.
- Sits on the transmit side of the UART top and drives the line sampled by the receiver.
- Intended for back-to-back streams: consecutive frames are emitted with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes enter a small circular FIFO through a valid/busy
// handshake and are serialised LSB-first (start, 8 data, STOP_BITS stop) on out_signal.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         out_BUSY,
  output logic                         out_drop,
  output logic [$clog2(FIFO_DEPTH):0]  out_level,
  output logic                         out_idle,
  output logic                         out_signal
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned LW        = AW + 1;
  localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned CW        = $clog2(STOP_CLKS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            line_q, line_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            busy_q, drop_q, idle_q;
  logic            push, pop, has_data, bit_done, stop_done;

  assign push      = in_valid && !busy_q;
  assign has_data  = (level_q != '0);
  assign bit_done  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign stop_done = (cnt_q == CW'(STOP_CLKS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (has_data) state_d = START;
      START: if (bit_done) state_d = DATA;
      DATA:  if (bit_done && bit_q == 3'd7) state_d = STOP;
      STOP:  if (stop_done) state_d = has_data ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output next values; a pop loads the shifter and drives the start bit
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        line_d = 1'b1;
        if (has_data) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          line_d  = 1'b0;
        end
      end
      START: if (bit_done) begin
        cnt_d  = '0;
        bit_d  = 3'd0;
        line_d = shift_q[0];
      end
      DATA: if (bit_done) begin
        cnt_d = '0;
        if (bit_q == 3'd7) begin
          line_d = 1'b1;
        end else begin
          shift_d = shift_q >> 1;
          line_d  = shift_q[1];
          bit_d   = bit_q + 3'd1;
        end
      end
      STOP: if (stop_done) begin
        cnt_d  = '0;
        line_d = 1'b1;
        if (has_data) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          line_d  = 1'b0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Idle tracks the FSM target and the occupancy seen before this edge's push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      line_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q  <= level_d;
      busy_q   <= (level_d == LW'(FIFO_DEPTH));
      drop_q   <= in_valid && busy_q;
      idle_q   <= (state_d == IDLE) && !has_data;
    end
  end

  assign out_signal = line_q;
  assign out_BUSY   = busy_q;
  assign out_drop   = drop_q;
  assign out_level  = level_q;
  assign out_idle   = idle_q;

endmodule
